// File: rtl/corr_pkg.sv
// Shared constants, FSM state encoding and index-width helper for the
// correlation peak controller.
package corr_pkg;

  localparam int DEF_SAMPLES = 128;
  localparam int DEF_OSF     = 8;
  localparam int DEF_MAG_W   = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } corr_state_t;

  // One spare bit so SAMPLES*OSF itself is representable.
  function automatic int corr_idx_w(input int samples, input int osf);
    return $clog2(samples * osf) + 1;
  endfunction

endpackage

// File: rtl/correlacion_peak_cmp.sv
// New-peak decision for one correlation sample (strict greater-than, earliest lag wins).
// Optional macro CORR_THRESHOLD_EN adds a minimum-magnitude qualification.
module correlacion_peak_cmp #(
  parameter int MAG_W = 24
) (
  input  logic [MAG_W-1:0] i_mag,
  input  logic [MAG_W-1:0] i_peak,
  input  logic             i_have,
`ifdef CORR_THRESHOLD_EN
  input  logic [MAG_W-1:0] i_threshold,
`endif
  output logic             o_new_peak
);

  logic w_beats;

  assign w_beats = !i_have || (i_mag > i_peak);

`ifdef CORR_THRESHOLD_EN
  assign o_new_peak = w_beats && (i_mag >= i_threshold);
`else
  assign o_new_peak = w_beats;
`endif

endmodule

// File: rtl/correlacion_peak_ctrl.sv
// Correlation sweep sequencer: scans SAMPLES*OSF lags and loads the winning lag
// into the downstream index register. Optional macro CORR_THRESHOLD_EN.
//
// state   | meaning
// IDLE    | waiting for Start, results held
// SCAN    | evaluating one lag per MagValid cycle
// DONE    | one-cycle end-of-sweep pulse
module correlacion_peak_ctrl
  import corr_pkg::*;
#(
  parameter int SAMPLES = DEF_SAMPLES,
  parameter int OSF     = DEF_OSF,
  parameter int MAG_W   = DEF_MAG_W,
  localparam int N      = SAMPLES * OSF,
  localparam int IDX_W  = corr_idx_w(SAMPLES, OSF)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MagValid,
  input  logic [MAG_W-1:0] Mag,
  output logic             Busy,
  output logic             LD,
  output logic [IDX_W-1:0] LdIdx,
  output logic [MAG_W-1:0] PeakMag,
`ifdef CORR_THRESHOLD_EN
  input  logic [MAG_W-1:0] Threshold,
  output logic             Found,
`endif
  output logic             Done
);

  localparam logic [IDX_W-1:0] LAST_LAG = IDX_W'(N - 1);

  corr_state_t      r_state;
  logic [IDX_W-1:0] r_cnt;
  logic             r_have;
  logic             r_ld;
  logic             r_done;
  logic [IDX_W-1:0] r_ld_idx;
  logic [MAG_W-1:0] r_peak;
  logic             w_new_peak;
`ifdef CORR_THRESHOLD_EN
  logic             r_found;
`endif

  correlacion_peak_cmp #(
    .MAG_W (MAG_W)
  ) u_cmp (
    .i_mag       (Mag),
    .i_peak      (r_peak),
    .i_have      (r_have),
`ifdef CORR_THRESHOLD_EN
    .i_threshold (Threshold),
`endif
    .o_new_peak  (w_new_peak)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_have   <= 1'b0;
      r_ld     <= 1'b0;
      r_done   <= 1'b0;
      r_ld_idx <= '0;
      r_peak   <= '0;
`ifdef CORR_THRESHOLD_EN
      r_found  <= 1'b0;
`endif
    end else begin
      r_ld   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_state  <= ST_SCAN;
            r_cnt    <= '0;
            r_have   <= 1'b0;
            r_ld_idx <= '0;
            r_peak   <= '0;
`ifdef CORR_THRESHOLD_EN
            r_found  <= 1'b0;
`endif
          end
        end
        ST_SCAN: begin
          if (MagValid) begin
            if (w_new_peak) begin
              r_ld     <= 1'b1;
              r_ld_idx <= r_cnt;
              r_peak   <= Mag;
              r_have   <= 1'b1;
`ifdef CORR_THRESHOLD_EN
              r_found  <= 1'b1;
`endif
            end
            // Counter parks on the last lag; the next Start re-arms it.
            if (r_cnt == LAST_LAG) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy    = (r_state != ST_IDLE);
  assign LD      = r_ld;
  assign LdIdx   = r_ld_idx;
  assign PeakMag = r_peak;
  assign Done    = r_done;
`ifdef CORR_THRESHOLD_EN
  assign Found   = r_found;
`endif

endmodule

// File: tb/tb_correlacion_peak_ctrl.sv
// Self-checking bench for correlacion_peak_ctrl (SAMPLES=4, OSF=2, MAG_W=8).
// Threshold cases are compiled only with CORR_THRESHOLD_EN.
module tb_correlacion_peak_ctrl;

  localparam int SAMPLES = 4;
  localparam int OSF     = 2;
  localparam int N       = SAMPLES * OSF;
  localparam int IDX_W   = 4;
  localparam int MAG_W   = 8;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic             MagValid;
  logic [MAG_W-1:0] Mag;
  logic             Busy;
  logic             LD;
  logic [IDX_W-1:0] LdIdx;
  logic [MAG_W-1:0] PeakMag;
  logic             Done;
`ifdef CORR_THRESHOLD_EN
  logic [MAG_W-1:0] Threshold;
  logic             Found;
`endif

  int checks = 0;
  int errors = 0;

  logic [MAG_W-1:0] mags [N];
  logic [MAG_W-1:0] thr_v = '0;
  bit               exp_ld [N];
  int               exp_idx;
  logic [MAG_W-1:0] exp_peak;
  bit               exp_found;

  correlacion_peak_ctrl #(
    .SAMPLES (SAMPLES),
    .OSF     (OSF),
    .MAG_W   (MAG_W)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .MagValid  (MagValid),
    .Mag       (Mag),
    .Busy      (Busy),
    .LD        (LD),
    .LdIdx     (LdIdx),
    .PeakMag   (PeakMag),
`ifdef CORR_THRESHOLD_EN
    .Threshold (Threshold),
    .Found     (Found),
`endif
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

`ifdef CORR_THRESHOLD_EN
  assign Threshold = thr_v;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // A lag loads when it qualifies and beats every earlier qualifying lag.
  function automatic void build_model();
    exp_idx   = 0;
    exp_peak  = '0;
    exp_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      bit win;
      win = (mags[k] >= thr_v);
      for (int j = 0; j < k; j++)
        if (mags[j] >= thr_v && mags[k] <= mags[j]) win = 1'b0;
      exp_ld[k] = win;
      if (win) begin
        exp_idx   = k;
        exp_peak  = mags[k];
        exp_found = 1'b1;
      end
    end
  endfunction

  // gap_mode: 0 no gaps, 1 one gap before each sample, 2 random 0..3 gaps.
  task automatic run_sweep(input int gap_mode, input bit pokes, input int n_samp);
    build_model();
    @(negedge Clk);
    Start    = 1'b1;
    MagValid = pokes;
    Mag      = 8'($urandom);
    step();
    chk("busy_start", 32'(Busy), 32'd1);
    chk("ld_start", 32'(LD), 32'd0);
    chk("peak_clr", 32'(PeakMag), 32'd0);
    chk("idx_clr", 32'(LdIdx), 32'd0);
`ifdef CORR_THRESHOLD_EN
    chk("found_clr", 32'(Found), 32'd0);
`endif
    for (int k = 0; k < n_samp; k++) begin
      int gaps;
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(3)) : 0;
      for (int g = 0; g < gaps; g++) begin
        @(negedge Clk);
        Start    = pokes;
        MagValid = 1'b0;
        Mag      = 8'($urandom);
        step();
        chk("gap_ld", 32'(LD), 32'd0);
        chk("gap_done", 32'(Done), 32'd0);
        chk("gap_busy", 32'(Busy), 32'd1);
      end
      @(negedge Clk);
      Start    = pokes;
      MagValid = 1'b1;
      Mag      = mags[k];
      step();
      chk($sformatf("ld_lag%0d", k), 32'(LD), 32'(exp_ld[k]));
      if (exp_ld[k]) begin
        chk($sformatf("idx_lag%0d", k), 32'(LdIdx), 32'(k));
        chk($sformatf("peak_lag%0d", k), 32'(PeakMag), 32'(mags[k]));
      end
      chk($sformatf("done_lag%0d", k), 32'(Done), 32'(k == N - 1));
    end
    if (n_samp < N) return;
    chk("busy_done", 32'(Busy), 32'd1);
    @(negedge Clk);
    Start    = pokes;
    MagValid = pokes;
    Mag      = 8'($urandom);
    step();
    chk("done_once", 32'(Done), 32'd0);
    chk("busy_idle", 32'(Busy), 32'd0);
    chk("ld_idle", 32'(LD), 32'd0);
    chk("final_idx", 32'(LdIdx), 32'(exp_idx));
    chk("final_peak", 32'(PeakMag), 32'(exp_peak));
`ifdef CORR_THRESHOLD_EN
    chk("final_found", 32'(Found), 32'(exp_found));
`endif
    @(negedge Clk);
    Start    = 1'b0;
    MagValid = 1'b0;
    step();
    chk("no_queued_start", 32'(Busy), 32'd0);
    chk("hold_idx", 32'(LdIdx), 32'(exp_idx));
  endtask

  initial begin
    Reset    = 1'b0;
    Start    = 1'b0;
    MagValid = 1'b0;
    Mag      = '0;
    repeat (3) step();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ld", 32'(LD), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_idx", 32'(LdIdx), 32'd0);
    chk("rst_peak", 32'(PeakMag), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    step();
    chk("idle_busy", 32'(Busy), 32'd0);

    // Ties at lags 3/6 must not reload.
    mags = '{8'd5, 8'd9, 8'd3, 8'd9, 8'd12, 8'd1, 8'd12, 8'd0};
    run_sweep(0, 1'b0, N);

    // Monotonic stream: every lag loads, last LD shares the Done cycle.
    for (int k = 0; k < N; k++) mags[k] = 8'(k + 1);
    run_sweep(0, 1'b0, N);

    // Same stream with alternate idle cycles and Start pokes throughout.
    run_sweep(1, 1'b1, N);

    // Reset after lag 3 discards the sweep.
    for (int k = 0; k < N; k++) mags[k] = 8'($urandom_range(200));
    run_sweep(0, 1'b0, 4);
    @(negedge Clk);
    Reset    = 1'b0;
    MagValid = 1'b1;
    Mag      = 8'd250;
    step();
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_ld", 32'(LD), 32'd0);
    chk("mid_rst_done", 32'(Done), 32'd0);
    chk("mid_rst_idx", 32'(LdIdx), 32'd0);
    chk("mid_rst_peak", 32'(PeakMag), 32'd0);
    @(negedge Clk);
    Reset    = 1'b1;
    MagValid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_done", 32'(Done), 32'd0);
      chk("post_rst_busy", 32'(Busy), 32'd0);
    end
    @(negedge Clk);
    MagValid = 1'b0;

    mags = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7};
    run_sweep(0, 1'b0, N);

    // Random sweeps with small magnitudes so ties are common.
    repeat (25) begin
      for (int k = 0; k < N; k++) mags[k] = 8'($urandom_range(15));
      run_sweep(2, 1'($urandom_range(1)), N);
    end

`ifdef CORR_THRESHOLD_EN
    thr_v = 8'd10;
    mags  = '{8'd5, 8'd9, 8'd3, 8'd9, 8'd12, 8'd1, 8'd12, 8'd0};
    run_sweep(0, 1'b0, N);
    for (int k = 0; k < N; k++) mags[k] = 8'($urandom_range(9));
    run_sweep(2, 1'b0, N);
    repeat (10) begin
      thr_v = 8'($urandom_range(15));
      for (int k = 0; k < N; k++) mags[k] = 8'($urandom_range(15));
      run_sweep(2, 1'($urandom_range(1)), N);
    end
    thr_v = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
